rca64_sub_serial: RTL and testbench
===================================

Name: rca64_sub_serial

Overview:
Digit-serial 64-bit unsigned subtractor, the inverse-direction companion of the 64-bit ripple-carry adder. It computes diff = op1 - op2 and a borrow-out. It processes DIGIT bits per clock through a shared ripple subtract slice, with a start/busy/done handshake. It sits beside the adder in the datapath, trading latency for area.

Parameters:
WIDTH, 64, operand and result width in bits.
DIGIT, 16, bits processed per cycle. WIDTH must be an integer multiple of DIGIT.
NUM_DIGITS, WIDTH/DIGIT (4), derived iteration count. Localparam, not overridable.

Ports:
clock  input  1  single clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only while idle.
op1  input  WIDTH  minuend; captured on the accepted start edge.
op2  input  WIDTH  subtrahend; captured on the accepted start edge.
diff  output  WIDTH  registered result, op1 - op2 mod 2^WIDTH.
brout  output  1  registered borrow-out; 1 iff op1 < op2 (unsigned).
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when diff/brout update.

Behaviour:
- Reset: sampled at the rising edge of clock while reset=1.
  - State returns to IDLE.
  - diff=0, brout=0, busy=0, done=0; digit counter and borrow register cleared.
  - Reset has priority over every other event.
- Internal arithmetic: op1 + ~op2 + 1, one DIGIT slice per cycle, least-significant digit first.
  - Inter-digit borrow register starts at 0.
  - brout = final borrow = NOT of the final carry.
- States:
  - IDLE: busy=0. On start=1, latch op1/op2 into operand registers, clear the counter and borrow, and go to RUN.
  - RUN: busy=1. Each cycle, compute digit k and write it into the partial-result register; update the borrow; increment k.
  - When k = NUM_DIGITS-1 is processed, load diff (full partial result) and brout, pulse done=1 for the next cycle, and return to IDLE.
- Latency:
  - start sampled at edge E0; done=1 and the new diff/brout are visible in the cycle after edge E0+NUM_DIGITS (4 edges at default parameters).
  - busy is 1 after E0 through edge E0+NUM_DIGITS, and 0 in the done cycle.
- Throughput:
  - The done cycle is an IDLE cycle, so start=1 in that cycle is accepted (back-to-back).
  - One result per NUM_DIGITS+1 cycles at most.
- start while busy=1: ignored. No queueing; latched operands unaffected.
- op1/op2 changing after acceptance: no effect on the in-flight result.
- diff and brout hold their last value between operations; they change only at the done update.
- Reset mid-operation: the operation is aborted, done never asserts for it, and outputs take their reset values.
- No partial result is ever visible on diff.

Decomposition:
- Shared package rca_pkg:
  - RCA_WIDTH=64, RCA_DIGIT=16 constants.
  - State encoding (IDLE, RUN).
- Sub-module rca_sub_digit:
  - Combinational DIGIT-bit ripple subtract slice.
  - Inputs a, b, borrow_in; outputs d, borrow_out.
  - Built from full-adder cells on a + ~b with carry_in = ~borrow_in.
- Top module holds the FSM, counter, operand and result registers, and muxes the active digit into the slice.

Test Plan:
- Hold reset=1 for 2 edges with start=1 -> diff=0, brout=0, busy=0, done=0 throughout.
- op1=64'h1010_1010_1199_ffff, op2=64'habcd_1100_1100_dddd, start for 1 cycle -> after 4 edges done=1 for exactly 1 cycle, diff=64'h6442_ff10_0099_2222, brout=1; busy high for exactly 4 cycles.
- op1=64'h0000_0000_0001_0000, op2=64'h1 (borrow across digit boundary) -> diff=64'h0000_0000_0000_ffff, brout=0. Also op1=0, op2=1 -> diff=64'hffff_ffff_ffff_ffff, brout=1. Also op1=op2=64'hdead_beef_0123_4567 -> diff=0, brout=0.
- Start A (op1=5, op2=3), change op1/op2 and pulse start during busy, then assert start in the done cycle with op1=1, op2=2 -> first done shows diff=2; the mid-busy start is ignored; second done exactly 5 cycles after the first shows diff=64'hffff_ffff_ffff_ffff, brout=1.
- Start an operation, assert reset for one edge at the 2nd RUN cycle -> busy=0 next cycle, no done pulse for the aborted operation, diff=0; a following fresh start completes correctly.

Source files
------------

// File: rtl/rca64_sub_serial_pkg.sv
// Shared constants and FSM encoding for the digit-serial 64-bit subtractor.
package rca64_sub_serial_pkg;
    localparam int RCA_WIDTH = 64;
    localparam int RCA_DIGIT = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/rca64_sub_serial_if.sv
// Request/response bundle between a requester and the serial subtractor.
interface rca64_sub_serial_if #(
    parameter int WIDTH = rca64_sub_serial_pkg::RCA_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] diff;
    logic             brout;
    logic             busy;
    logic             done;

    modport master (output start, op1, op2, input diff, brout, busy, done);
    modport slave  (input start, op1, op2, output diff, brout, busy, done);
endinterface

// File: rtl/rca64_sub_serial_digit.sv
// Combinational DIGIT-bit ripple subtract slice: a + ~b with carry-in = ~borrow_in.
module rca_sub_digit #(
    parameter int DIGIT = rca64_sub_serial_pkg::RCA_DIGIT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             borrow_in,
    output logic [DIGIT-1:0] d,
    output logic             borrow_out
);
    logic [DIGIT:0] c;

    assign c[0] = ~borrow_in;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic nb;
        assign nb       = ~b[i];
        assign d[i]     = a[i] ^ nb ^ c[i];
        assign c[i+1]   = (a[i] & nb) | (a[i] & c[i]) | (nb & c[i]);
    end

    // Borrow is the complement of the carry leaving the slice.
    assign borrow_out = ~c[DIGIT];
endmodule

// File: rtl/rca64_sub_serial.sv
// Digit-serial unsigned subtractor: one DIGIT slice per clock, LSD first, start/busy/done handshake.
module rca64_sub_serial
    import rca64_sub_serial_pkg::*;
#(
    parameter int WIDTH = RCA_WIDTH,
    parameter int DIGIT = RCA_DIGIT
) (
    input  logic               clock,
    input  logic               reset,
    rca64_sub_serial_if.slave  bus
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_DIGITS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   part_q, part_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               brout_q, brout_d;
    logic               done_q, done_d;

    logic [DIGIT-1:0]   slice_a, slice_b, slice_d;
    logic               slice_bout;

    assign slice_a = a_q[cnt_q*DIGIT +: DIGIT];
    assign slice_b = b_q[cnt_q*DIGIT +: DIGIT];

    rca_sub_digit #(.DIGIT(DIGIT)) u_slice (
        .a          (slice_a),
        .b          (slice_b),
        .borrow_in  (borrow_q),
        .d          (slice_d),
        .borrow_out (slice_bout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            brout_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            brout_q  <= brout_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        diff_d   = diff_q;
        brout_d  = brout_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.op1;
                    b_d      = bus.op2;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                part_d[cnt_q*DIGIT +: DIGIT] = slice_d;
                borrow_d = slice_bout;
                cnt_d    = cnt_q + 1'b1;
                // Result registers only ever see the completed word.
                if (cnt_q == CNT_LAST) begin
                    diff_d  = part_d;
                    brout_d = slice_bout;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == ST_RUN);
        bus.done  = done_q;
        bus.diff  = diff_q;
        bus.brout = brout_q;
    end
endmodule

// File: tb/tb_rca64_sub_serial.sv
// Directed and random checks of the serial subtractor against plain 64-bit arithmetic.
module tb_rca64_sub_serial;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    rca64_sub_serial_if bus ();

    rca64_sub_serial dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Steps until done or budget expires; returns edges consumed and busy cycles seen.
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            if (bus.busy === 1'b1) bc++;
            step();
            n++;
        end
    endtask

    task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b);
        int n, bc;
        logic [63:0] exp_d;
        logic        exp_b;
        exp_d = a - b;
        exp_b = (a < b);
        bus.op1   = a;
        bus.op2   = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n, bc);
        chk({tag, "_lat"},   64'(n), 64'd4);
        chk({tag, "_busyn"}, 64'(bc), 64'd4);
        chk({tag, "_busy0"}, 64'(bus.busy), 64'd0);
        chk({tag, "_diff"},  bus.diff, exp_d);
        chk({tag, "_brout"}, 64'(bus.brout), 64'(exp_b));
        step();
        chk({tag, "_done1"}, 64'(bus.done), 64'd0);
        chk({tag, "_hold"},  bus.diff, exp_d);
    endtask

    initial begin
        int n, bc, dcount;
        logic [63:0] ra, rb;

        reset = 1'b1;
        bus.start = 1'b1;
        bus.op1 = 64'hffff_ffff_ffff_ffff;
        bus.op2 = 64'h1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_diff",  bus.diff, 64'd0);
            chk("rst_brout", 64'(bus.brout), 64'd0);
            chk("rst_busy",  64'(bus.busy), 64'd0);
            chk("rst_done",  64'(bus.done), 64'd0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        step();

        do_op("vec1",  64'h1010_1010_1199_ffff, 64'habcd_1100_1100_dddd);
        chk("vec1_lit", bus.diff, 64'h6442_ff10_0099_2222);
        do_op("bnd",   64'h0000_0000_0001_0000, 64'h1);
        chk("bnd_lit", bus.diff, 64'h0000_0000_0000_ffff);
        do_op("zero1", 64'h0, 64'h1);
        do_op("eq",    64'hdead_beef_0123_4567, 64'hdead_beef_0123_4567);

        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (i == 3) rb = ra;
            if (i == 4) rb = ra + 64'd1;
            if (i == 5) ra = 64'hffff_ffff_ffff_ffff;
            do_op($sformatf("rnd%0d", i), ra, rb);
        end

        // Mid-busy start ignored, then back-to-back start in the done cycle.
        bus.op1 = 64'd5;
        bus.op2 = 64'd3;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.op1 = 64'h1234;
        bus.op2 = 64'h9999;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n, bc);
        chk("b2b_first_done", 64'(bus.done), 64'd1);
        chk("b2b_first_diff", bus.diff, 64'd2);
        chk("b2b_first_brout", 64'(bus.brout), 64'd0);
        bus.op1 = 64'd1;
        bus.op2 = 64'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_done(n, bc);
        chk("b2b_gap",    64'(n + 1), 64'd5);
        chk("b2b_diff",   bus.diff, 64'hffff_ffff_ffff_ffff);
        chk("b2b_brout",  64'(bus.brout), 64'd1);
        step();

        // Abort with reset in the second RUN cycle.
        bus.op1 = 64'h7777;
        bus.op2 = 64'h1111;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy",  64'(bus.busy), 64'd0);
        chk("abort_diff",  bus.diff, 64'd0);
        chk("abort_brout", 64'(bus.brout), 64'd0);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) dcount++;
            step();
        end
        chk("abort_nodone", 64'(dcount), 64'd0);
        do_op("post_abort", 64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
